// File: rtl/cpu_params_pkg.sv
// Shared CPU parameters for the CSR access path: data width, CSR op encoding,
// CSR address field positions and the read-modify-write helper.
package cpu_params_pkg;

    // CSR data width
    localparam int RSZ = 32;

    // CSR instruction operation as presented by the pipeline
    typedef enum logic [1:0] {
        CSR_OP_ILL = 2'b00,
        CSR_OP_RW  = 2'b01,
        CSR_OP_RS  = 2'b10,
        CSR_OP_RC  = 2'b11
    } csr_op_t;

    // Address fields, given as offsets from ADDR_W:
    //   read-only space field = addr[ADDR_W-1 : ADDR_W-2]
    //   minimum privilege     = addr[ADDR_W-3 : ADDR_W-4]
    localparam int         CSR_RO_MSB_OFS   = 1;
    localparam int         CSR_PRIV_MSB_OFS = 3;
    localparam logic [1:0] CSR_RO_SPACE     = 2'b11;

    // New register value for a read-modify-write
    function automatic logic [RSZ-1:0] csr_new_value(
        input csr_op_t        op,
        input logic [RSZ-1:0] old_val,
        input logic [RSZ-1:0] wdata
    );
        logic [RSZ-1:0] result;
        case (op)
            CSR_OP_RW: result = wdata;
            CSR_OP_RS: result = old_val | wdata;
            CSR_OP_RC: result = old_val & ~wdata;
            default:   result = old_val;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/csr_arb.sv
// Trap/pipe arbiter for the CSR store. The trap port normally wins, but once
// TRAP_BURST trap grants have been made while a pipe request was waiting, the
// pipe gets the next grant. Grants are combinational and only given while
// arb_en is high (controller idle).
module csr_arb #(
    parameter int TRAP_BURST = 2
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic arb_en,
    input  logic pipe_valid,
    input  logic trap_valid,
    output logic pipe_grant,
    output logic trap_grant
);
    localparam int CW = (TRAP_BURST < 1) ? 1 : $clog2(TRAP_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(TRAP_BURST);

    logic [CW-1:0] burst_cnt;
    logic          pipe_starved;

    assign pipe_starved = pipe_valid && (burst_cnt == BURST_MAX);
    assign trap_grant   = arb_en && trap_valid && !pipe_starved;
    assign pipe_grant   = arb_en && pipe_valid && !trap_grant;

    // Count trap grants made while the pipe waits; clear on a pipe grant, saturate at the limit
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            burst_cnt <= '0;
        end else if (pipe_grant) begin
            burst_cnt <= '0;
        end else if (trap_grant && pipe_valid && (burst_cnt != BURST_MAX)) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// CSR access controller: serialises pipeline CSR read-modify-write requests
// (IDLE -> READ -> [WRITE] -> RESP) and single-cycle trap-unit writes onto one
// CSR store port. Build option: define CSR_TRAP_PORT_EN to enable the trap
// port and its arbitration; otherwise the trap port is inert and the pipe is
// always granted.
module csr_access_ctrl
    import cpu_params_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int TRAP_BURST = 2
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              pipe_req_valid,
    output logic              pipe_req_ready,
    input  logic [1:0]        pipe_op,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [RSZ-1:0]    pipe_wdata,
    input  logic              pipe_wr_suppress,
    input  logic [1:0]        priv_mode,
    output logic              pipe_rsp_valid,
    input  logic              pipe_rsp_ready,
    output logic [RSZ-1:0]    pipe_rsp_rdata,
    output logic              pipe_rsp_illegal,
    input  logic              trap_req_valid,
    output logic              trap_req_ready,
    input  logic [ADDR_W-1:0] trap_addr,
    input  logic [RSZ-1:0]    trap_wdata,
    output logic [ADDR_W-1:0] csr_rd_addr,
    input  logic [RSZ-1:0]    csr_rd_data,
    output logic              csr_wr_en,
    output logic [ADDR_W-1:0] csr_wr_addr,
    output logic [RSZ-1:0]    csr_wr_data
);
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_t;

    state_t            state;
    logic              run;        // low for the first cycle after reset so no grant races reset release
    csr_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [RSZ-1:0]    wdata_q;
    logic              suppress_q;
    logic [1:0]        priv_q;
    logic [RSZ-1:0]    old_q;

    logic arb_en, pipe_grant, trap_grant;
    logic ro_space, no_write, illegal_now;
    logic [1:0] priv_field;

    assign arb_en = run && (state == ST_IDLE);

`ifdef CSR_TRAP_PORT_EN
    csr_arb #(.TRAP_BURST(TRAP_BURST)) u_arb (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .arb_en     (arb_en),
        .pipe_valid (pipe_req_valid),
        .trap_valid (trap_req_valid),
        .pipe_grant (pipe_grant),
        .trap_grant (trap_grant)
    );
`else
    assign pipe_grant = arb_en && pipe_req_valid;
    assign trap_grant = 1'b0;
    logic unused_trap;
    assign unused_trap = ^{trap_req_valid, trap_addr, trap_wdata};
`endif

    assign pipe_req_ready = pipe_grant;
    assign trap_req_ready = trap_grant;

    // Legality of the latched request, evaluated while in READ
    assign priv_field  = addr_q[ADDR_W-CSR_PRIV_MSB_OFS -: 2];
    assign ro_space    = (addr_q[ADDR_W-CSR_RO_MSB_OFS -: 2] == CSR_RO_SPACE);
    assign no_write    = suppress_q && ((op_q == CSR_OP_RS) || (op_q == CSR_OP_RC));
    assign illegal_now = (op_q == CSR_OP_ILL) || (priv_field > priv_q) || (ro_space && !no_write);

    assign csr_rd_addr = (state == ST_READ) ? addr_q : '0;

    // Store write port: pipe write in WRITE, trap write in its accept cycle (IDLE only)
    always_comb begin
        csr_wr_en   = 1'b0;
        csr_wr_addr = '0;
        csr_wr_data = '0;
        if (state == ST_WRITE) begin
            csr_wr_en   = 1'b1;
            csr_wr_addr = addr_q;
            csr_wr_data = csr_new_value(op_q, old_q, wdata_q);
        end else if (trap_grant) begin
            csr_wr_en   = 1'b1;
            csr_wr_addr = trap_addr;
            csr_wr_data = trap_wdata;
        end
    end

    // Transaction FSM with registered response outputs
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state            <= ST_IDLE;
            run              <= 1'b0;
            op_q             <= CSR_OP_ILL;
            addr_q           <= '0;
            wdata_q          <= '0;
            suppress_q       <= 1'b0;
            priv_q           <= 2'b00;
            old_q            <= '0;
            pipe_rsp_valid   <= 1'b0;
            pipe_rsp_rdata   <= '0;
            pipe_rsp_illegal <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (pipe_grant) begin
                        op_q       <= csr_op_t'(pipe_op);
                        addr_q     <= pipe_addr;
                        wdata_q    <= pipe_wdata;
                        suppress_q <= pipe_wr_suppress;
                        priv_q     <= priv_mode;
                        state      <= ST_READ;
                    end
                end
                ST_READ: begin
                    old_q <= csr_rd_data;
                    if (illegal_now) begin
                        pipe_rsp_valid   <= 1'b1;
                        pipe_rsp_rdata   <= '0;
                        pipe_rsp_illegal <= 1'b1;
                        state            <= ST_RESP;
                    end else if (no_write) begin
                        pipe_rsp_valid   <= 1'b1;
                        pipe_rsp_rdata   <= csr_rd_data;
                        pipe_rsp_illegal <= 1'b0;
                        state            <= ST_RESP;
                    end else begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    pipe_rsp_valid   <= 1'b1;
                    pipe_rsp_rdata   <= old_q;
                    pipe_rsp_illegal <= 1'b0;
                    state            <= ST_RESP;
                end
                ST_RESP: begin
                    if (pipe_rsp_ready) begin
                        pipe_rsp_valid   <= 1'b0;
                        pipe_rsp_rdata   <= '0;
                        pipe_rsp_illegal <= 1'b0;
                        state            <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed testbench for csr_access_ctrl with a behavioural CSR store.
// Arbitration vectors run when CSR_TRAP_PORT_EN is defined; otherwise the
// bench checks that the trap port stays inert.
module tb_csr_access_ctrl;
    import cpu_params_pkg::*;

    localparam int ADDR_W = 12;

    logic              clk_in = 1'b0;
    logic              reset_in;
    logic              pipe_req_valid, pipe_req_ready;
    logic [1:0]        pipe_op;
    logic [ADDR_W-1:0] pipe_addr;
    logic [RSZ-1:0]    pipe_wdata;
    logic              pipe_wr_suppress;
    logic [1:0]        priv_mode;
    logic              pipe_rsp_valid, pipe_rsp_ready;
    logic [RSZ-1:0]    pipe_rsp_rdata;
    logic              pipe_rsp_illegal;
    logic              trap_req_valid, trap_req_ready;
    logic [ADDR_W-1:0] trap_addr;
    logic [RSZ-1:0]    trap_wdata;
    logic [ADDR_W-1:0] csr_rd_addr;
    logic [RSZ-1:0]    csr_rd_data;
    logic              csr_wr_en;
    logic [ADDR_W-1:0] csr_wr_addr;
    logic [RSZ-1:0]    csr_wr_data;

    csr_access_ctrl #(.ADDR_W(ADDR_W), .TRAP_BURST(2)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .pipe_req_valid(pipe_req_valid), .pipe_req_ready(pipe_req_ready),
        .pipe_op(pipe_op), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .pipe_wr_suppress(pipe_wr_suppress), .priv_mode(priv_mode),
        .pipe_rsp_valid(pipe_rsp_valid), .pipe_rsp_ready(pipe_rsp_ready),
        .pipe_rsp_rdata(pipe_rsp_rdata), .pipe_rsp_illegal(pipe_rsp_illegal),
        .trap_req_valid(trap_req_valid), .trap_req_ready(trap_req_ready),
        .trap_addr(trap_addr), .trap_wdata(trap_wdata),
        .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data),
        .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural CSR store
    logic [RSZ-1:0] store [0:(1<<ADDR_W)-1];
    assign csr_rd_data = store[csr_rd_addr];
    always @(posedge clk_in) if (csr_wr_en) store[csr_wr_addr] = csr_wr_data;

    // Cycle counter and write monitor
    int             cyc = 0;
    int             wr_cnt = 0;
    int             wr_cyc = 0;
    logic [ADDR_W-1:0] wr_addr_seen = '0;
    logic [RSZ-1:0]    wr_data_seen = '0;
    always @(posedge clk_in) cyc = cyc + 1;
    always @(negedge clk_in) begin
        if (csr_wr_en) begin
            wr_cnt       = wr_cnt + 1;
            wr_cyc       = cyc;
            wr_addr_seen = csr_wr_addr;
            wr_data_seen = csr_wr_data;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        else begin
            n_pass++;
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic wait_neg();
        @(negedge clk_in); #1;
    endtask

    // One pipe transaction; hold>0 keeps rsp_ready low that many cycles with a trap request pending
    task automatic pipe_txn(input string tag, input logic [1:0] op, input logic [11:0] addr,
                            input logic [31:0] wdata, input logic sup, input logic [1:0] priv,
                            input logic [31:0] exp_rdata, input logic exp_ill, input int exp_wr,
                            input logic [31:0] exp_wdata, input int exp_lat, input int hold);
        int   c0, w0, lat;
        logic seen;
        @(posedge clk_in); #1;
        pipe_rsp_ready = (hold == 0);
        pipe_req_valid = 1'b1; pipe_op = op; pipe_addr = addr; pipe_wdata = wdata;
        pipe_wr_suppress = sup; priv_mode = priv;
        c0 = cyc; w0 = wr_cnt;
        wait_neg();
        check({tag, " req_ready"}, 32'(pipe_req_ready), 32'd1);
        @(posedge clk_in); #1;
        pipe_req_valid = 1'b0; pipe_op = 2'b00; pipe_addr = 12'hFFF;
        pipe_wdata = 32'hDEAD_BEEF; pipe_wr_suppress = 1'b0; priv_mode = 2'b00;
        if (hold > 0) begin
            trap_req_valid = 1'b1; trap_addr = 12'h341; trap_wdata = 32'h0000_BEEF;
        end
        seen = 1'b0; lat = 0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            wait_neg();
            if (i == 1) check({tag, " rd_addr"}, 32'(csr_rd_addr), 32'(addr));
            if (pipe_rsp_valid) begin seen = 1'b1; lat = cyc - c0; end
        end
        check({tag, " rsp_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, pipe_rsp_rdata, exp_rdata);
        check({tag, " illegal"}, 32'(pipe_rsp_illegal), 32'(exp_ill));
        check({tag, " wr_count"}, 32'(wr_cnt - w0), 32'(exp_wr));
        if (exp_wr != 0) begin
            check({tag, " wr_addr"}, 32'(wr_addr_seen), 32'(addr));
            check({tag, " wr_data"}, wr_data_seen, exp_wdata);
            check({tag, " wr_cycle"}, 32'(wr_cyc - c0), 32'd2);
        end
        for (int i = 0; i < hold; i++) begin
            wait_neg();
            check({tag, " hold_valid"}, 32'(pipe_rsp_valid), 32'd1);
            check({tag, " hold_rdata"}, pipe_rsp_rdata, exp_rdata);
            check({tag, " hold_trap_rdy"}, 32'(trap_req_ready), 32'd0);
        end
        if (hold > 0) begin
            @(posedge clk_in); #1; pipe_rsp_ready = 1'b1;
            @(posedge clk_in);
        end
        wait_neg();
        check({tag, " rsp_done"}, 32'(pipe_rsp_valid), 32'd0);
        if (hold > 0) begin
`ifdef CSR_TRAP_PORT_EN
            check({tag, " trap_after_idle"}, 32'(trap_req_ready), 32'd1);
            check({tag, " trap_wr_addr"}, 32'(csr_wr_addr), 32'h341);
`else
            check({tag, " trap_inert"}, 32'(trap_req_ready), 32'd0);
            check({tag, " trap_no_wr"}, 32'(csr_wr_en), 32'd0);
`endif
            @(posedge clk_in); #1; trap_req_valid = 1'b0;
        end
    endtask

    initial begin
        int   w0, ng;
        logic saw_rsp;
        logic [11:0] seq;
        for (int i = 0; i < (1 << ADDR_W); i++) store[i] = '0;
        store[12'h300] = 32'h1;
        store[12'hC00] = 32'h55;
        store[12'h100] = 32'h42;

        // Reset with requests pending: everything must stay quiet
        reset_in = 1'b0; pipe_rsp_ready = 1'b1;
        pipe_req_valid = 1'b1; pipe_op = 2'b01; pipe_addr = 12'h300; pipe_wdata = 32'h7;
        pipe_wr_suppress = 1'b0; priv_mode = 2'b11;
        trap_req_valid = 1'b1; trap_addr = 12'h340; trap_wdata = 32'h99;
        repeat (2) wait_neg();
        check("rst req_ready", 32'(pipe_req_ready), 32'd0);
        check("rst trap_ready", 32'(trap_req_ready), 32'd0);
        check("rst rsp_valid", 32'(pipe_rsp_valid), 32'd0);
        check("rst rsp_rdata", pipe_rsp_rdata, 32'd0);
        check("rst illegal", 32'(pipe_rsp_illegal), 32'd0);
        check("rst wr_en", 32'(csr_wr_en), 32'd0);
        check("rst rd_addr", 32'(csr_rd_addr), 32'd0);
        check("rst wr_addr", 32'(csr_wr_addr), 32'd0);
        check("rst wr_data", csr_wr_data, 32'd0);
        pipe_req_valid = 1'b0; trap_req_valid = 1'b0;
        @(posedge clk_in); #1; reset_in = 1'b1;
        repeat (2) @(posedge clk_in);

        //       tag         op     addr     wdata  sup pr  rdata  ill wr  wdata   lat hold
        pipe_txn("rs_300",   2'b10, 12'h300, 32'h8,  0, 3, 32'h1,  0, 1, 32'h9,  3, 0);
        pipe_txn("rc_sup_c00",2'b11,12'hC00, 32'hF,  1, 0, 32'h55, 0, 0, 32'h0,  2, 0);
        pipe_txn("rw_priv0", 2'b01, 12'h300, 32'h3,  0, 0, 32'h0,  1, 0, 32'h0,  2, 0);
        pipe_txn("rw_300",   2'b01, 12'h300, 32'hA5, 0, 3, 32'h9,  0, 1, 32'hA5, 3, 0);
        pipe_txn("rc_300",   2'b11, 12'h300, 32'hF,  0, 3, 32'hA5, 0, 1, 32'hA0, 3, 0);
        pipe_txn("op00",     2'b00, 12'h300, 32'h1,  0, 3, 32'h0,  1, 0, 32'h0,  2, 0);
        pipe_txn("rw_ro",    2'b01, 12'hC00, 32'h1,  0, 3, 32'h0,  1, 0, 32'h0,  2, 0);
        pipe_txn("rs_ro_nosup",2'b10,12'hC00,32'h1,  0, 3, 32'h0,  1, 0, 32'h0,  2, 0);
        pipe_txn("rs_sup_300",2'b10,12'h300, 32'hFF, 1, 3, 32'hA0, 0, 0, 32'h0,  2, 0);
        pipe_txn("rs_priv_eq",2'b10,12'h200, 32'h1,  1, 2, 32'h0,  0, 0, 32'h0,  2, 0);
        pipe_txn("rw_hold",  2'b01, 12'h100, 32'h77, 0, 1, 32'h42, 0, 1, 32'h77, 3, 5);

        // Reset while the controller is in READ: no write, no response
        @(posedge clk_in); #1;
        pipe_req_valid = 1'b1; pipe_op = 2'b01; pipe_addr = 12'h300; pipe_wdata = 32'h1234;
        pipe_wr_suppress = 1'b0; priv_mode = 2'b11;
        w0 = wr_cnt;
        @(posedge clk_in); #1;
        pipe_req_valid = 1'b0;
        check("midrst in_read", 32'(csr_rd_addr), 32'h300);
        #2 reset_in = 1'b0;
        #1;
        check("midrst rd_addr", 32'(csr_rd_addr), 32'd0);
        check("midrst wr_en", 32'(csr_wr_en), 32'd0);
        check("midrst rsp_valid", 32'(pipe_rsp_valid), 32'd0);
        repeat (2) @(posedge clk_in);
        #1 reset_in = 1'b1;
        saw_rsp = 1'b0;
        repeat (6) begin
            wait_neg();
            if (pipe_rsp_valid) saw_rsp = 1'b1;
        end
        check("midrst no_rsp", 32'(saw_rsp), 32'd0);
        check("midrst no_write", 32'(wr_cnt - w0), 32'd0);

        // Trap and pipe both requesting every cycle
        @(posedge clk_in); #1;
        pipe_rsp_ready = 1'b1;
        pipe_req_valid = 1'b1; pipe_op = 2'b10; pipe_addr = 12'h300; pipe_wdata = 32'h1;
        pipe_wr_suppress = 1'b1; priv_mode = 2'b11;
        trap_req_valid = 1'b1; trap_addr = 12'h340; trap_wdata = 32'h1234;
        w0 = wr_cnt; ng = 0; seq = '0;
`ifdef CSR_TRAP_PORT_EN
        for (int i = 0; i < 60 && ng < 6; i++) begin
            wait_neg();
            if (trap_req_valid && trap_req_ready) begin seq = {seq[9:0], 2'b01}; ng++; end
            else if (pipe_req_valid && pipe_req_ready) begin seq = {seq[9:0], 2'b10}; ng++; end
        end
        @(posedge clk_in); #1;
        pipe_req_valid = 1'b0; trap_req_valid = 1'b0;
        repeat (6) @(posedge clk_in);
        check("arb grants", 32'(ng), 32'd6);
        check("arb order TTPTTP", 32'(seq), 32'h596);
        check("arb trap_writes", 32'(wr_cnt - w0), 32'd4);
        check("arb trap_value", store[12'h340], 32'h1234);
`else
        for (int i = 0; i < 3; i++) begin
            wait_neg();
            if (i == 0) check("notrap pipe_ready", 32'(pipe_req_ready), 32'd1);
            check("notrap trap_ready", 32'(trap_req_ready), 32'd0);
        end
        pipe_req_valid = 1'b0; trap_req_valid = 1'b0;
        repeat (6) @(posedge clk_in);
        check("notrap no_writes", 32'(wr_cnt - w0), 32'd0);
        check("notrap ng", 32'(ng + 32'(seq)), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule
